ls_exec_unit: RTL and testbench
===============================

Name: ls_exec_unit

Overview:
- Consumer end of the load/store issue interface. Accepts one in-order load or store per issue pulse from the load/store station and computes the effective address.
- Performs the data-memory access over a req/ack handshake, then reports completion on the CDB through a req/grant handshake.
- Drives lsu_busy back to the station's stall_hazard so that only one memory op is in flight at a time.

Parameters:
- DW, 16, datapath width for register data, address and memory data. immed is sign-extended from 16 bits when DW > 16.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- issue_in  in  1  station issued an op this cycle
- p_rd_in  in  6  destination physical register (load target)
- rob_num_in  in  4  ROB tag of the issued op
- mem_ren_in  in  1  op is a load
- mem_wen_in  in  1  op is a store
- immed_in  in  16  address offset
- rs_data  in  DW  base register value, read from PRF in the issue cycle
- rt_data  in  DW  store data, read from PRF in the issue cycle
- recover  in  1  branch/jump recovery
- rob_num_rec  in  4  ROB tag to flush
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  DW  effective address
- mem_wdata  out  DW  store data
- mem_ack  in  1  memory accepted the request (write) or returned data (read)
- mem_rdata  in  DW  load data, valid with mem_ack
- cdb_req  out  1  request CDB slot
- cdb_grant  in  1  CDB slot granted this cycle
- complete_out  out  1  completion broadcast this cycle
- p_rd_compl_out  out  6  completing physical register
- RegDest_compl_out  out  1  1 for loads, 0 for stores
- rob_num_compl_out  out  4  completing ROB tag
- result_out  out  DW  load data (0 for stores)
- lsu_busy  out  1  unit holds an op; station must not issue

Behaviour:
- States: IDLE, MEM, CDB. Registered op fields: p_rd, rob_num, is_ld, addr, wdata, data.
- Reset (async, rst low): state = IDLE and all op registers = 0. Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cdb_req=0, complete_out=0, p_rd_compl_out=0, RegDest_compl_out=0, rob_num_compl_out=0, result_out=0, lsu_busy=0.
- Accepting an op: in IDLE, if issue_in && !recover && (mem_ren_in || mem_wen_in), latch the fields and go to MEM.
  - addr = rs_data + sext(immed_in), truncated to DW, wrap-around allowed.
  - is_ld = mem_ren_in. If both mem_ren_in and mem_wen_in are set, the op is treated as a load.
- issue_in is ignored when the state is not IDLE (protocol violation), when recover=1, or when both mem_ren_in and mem_wen_in are 0.
- MEM state:
  - mem_req=1, mem_we=!is_ld, mem_addr=addr, mem_wdata=wdata. These are held stable until mem_ack.
  - On mem_ack: if is_ld, data <= mem_rdata. Go to CDB.
  - mem_ack in the first MEM cycle is legal.
- CDB state:
  - cdb_req=1. p_rd_compl_out=p_rd, RegDest_compl_out=is_ld, rob_num_compl_out=rob_num, result_out = is_ld ? data : 0.
  - complete_out = cdb_req && cdb_grant (combinational). When it fires, go to IDLE.
  - Stores also complete through the CDB so the ROB can retire them.
- Outside the CDB state: cdb_req=0, complete_out=0, and the completion outputs hold their last values.
- lsu_busy = (state != IDLE), registered. It is therefore 1 in the cycle after the accepting issue, through the cycle complete_out fires.
- Issue is accepted again in the cycle after completion.
- Latency: issue at cycle N; mem_req from N+1. With ack at N+1 and grant at N+2, complete_out fires at N+2.
- Recovery: if recover && state != IDLE && rob_num == rob_num_rec:
  - Go to IDLE next cycle; mem_req and cdb_req drop next cycle. No completion is broadcast.
  - A same-cycle mem_ack is discarded. A same-cycle cdb_grant is lost, because complete_out is gated by !flush_match.
  - The memory side must tolerate a withdrawn request.
- recover with a non-matching tag has no effect.
- Reset mid-operation aborts immediately; any outstanding request is dropped.

Test Plan:
- Load, fast path: rs_data=0x0100, immed=0xFFFC, p_rd=5, rob=3, mem_ack at N+1 with rdata=0xBEEF, grant at N+2 -> mem_addr=0x00FC, mem_we=0; complete_out at N+2 with p_rd=5, RegDest=1, rob=3, result=0xBEEF.
- Store: rs=0x0010, immed=4, rt=0x1234, rob=7 -> mem_req with mem_we=1, addr=0x0014, wdata=0x1234; after ack and grant, complete_out=1 with RegDest=0, rob=7, result=0.
- Stalls: ack delayed 3 cycles, grant delayed 2 cycles -> mem_req and addr stable for 4 cycles, cdb_req high 3 cycles, exactly one complete_out pulse; lsu_busy=1 throughout, 0 the next cycle.
- Recovery: in MEM with rob=9, assert recover with rob_num_rec=9 -> IDLE next cycle, no complete_out. Repeat with rob_num_rec=8 -> op completes normally.
- Back-to-back: issue a second op while busy -> it is ignored; issue it again the cycle after complete_out -> it is accepted.
- Reset: drop rst while in CDB state -> all outputs 0 immediately, lsu_busy=0.

Source files
------------

// File: rtl/ls_exec_unit_if.sv
// Data-memory request/acknowledge bus between the load/store execution unit
// (master) and the data memory (slave).
interface ls_exec_unit_if #(
  parameter int DW = 16
);
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/ls_exec_unit.sv
// Load/store execution unit: takes one in-order memory op from the station,
// performs the data-memory access, then broadcasts completion on the CDB.
module ls_exec_unit #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_in,
  input  logic [5:0]    p_rd_in,
  input  logic [3:0]    rob_num_in,
  input  logic          mem_ren_in,
  input  logic          mem_wen_in,
  input  logic [15:0]   immed_in,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic          recover,
  input  logic [3:0]    rob_num_rec,
  ls_exec_unit_if.master mem,
  output logic          cdb_req,
  input  logic          cdb_grant,
  output logic          complete_out,
  output logic [5:0]    p_rd_compl_out,
  output logic          RegDest_compl_out,
  output logic [3:0]    rob_num_compl_out,
  output logic [DW-1:0] result_out,
  output logic          lsu_busy
);

  typedef enum logic [1:0] {IDLE, MEM, CDB} state_t;

  state_t        state;
  logic [5:0]    p_rd;
  logic [3:0]    rob_num;
  logic          is_ld;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          mem_req_r;
  logic          mem_we_r;
  logic [DW-1:0] imm_ext;
  logic          flush_match;
  logic          accept;

  assign imm_ext     = DW'($signed(immed_in));
  assign flush_match = recover && (state != IDLE) && (rob_num == rob_num_rec);
  assign accept      = issue_in && !recover && (mem_ren_in || mem_wen_in);

  assign mem.mem_req   = mem_req_r;
  assign mem.mem_we    = mem_we_r;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wdata;

  // A flush in the grant cycle suppresses the broadcast even though cdb_req is high.
  assign complete_out = cdb_req && cdb_grant && !flush_match;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      p_rd              <= '0;
      rob_num           <= '0;
      is_ld             <= 1'b0;
      addr              <= '0;
      wdata             <= '0;
      mem_req_r         <= 1'b0;
      mem_we_r          <= 1'b0;
      cdb_req           <= 1'b0;
      lsu_busy          <= 1'b0;
      p_rd_compl_out    <= '0;
      RegDest_compl_out <= 1'b0;
      rob_num_compl_out <= '0;
      result_out        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= MEM;
            p_rd      <= p_rd_in;
            rob_num   <= rob_num_in;
            is_ld     <= mem_ren_in;
            addr      <= rs_data + imm_ext;
            wdata     <= rt_data;
            mem_req_r <= 1'b1;
            mem_we_r  <= !mem_ren_in;
            lsu_busy  <= 1'b1;
          end
        end
        MEM: begin
          if (flush_match) begin
            state     <= IDLE;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            lsu_busy  <= 1'b0;
          end else if (mem.mem_ack) begin
            // Completion fields are loaded here so they only change on entry to CDB.
            state             <= CDB;
            mem_req_r         <= 1'b0;
            mem_we_r          <= 1'b0;
            cdb_req           <= 1'b1;
            p_rd_compl_out    <= p_rd;
            RegDest_compl_out <= is_ld;
            rob_num_compl_out <= rob_num;
            result_out        <= is_ld ? mem.mem_rdata : '0;
          end
        end
        CDB: begin
          if (flush_match || cdb_grant) begin
            state    <= IDLE;
            cdb_req  <= 1'b0;
            lsu_busy <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
          cdb_req   <= 1'b0;
          lsu_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ls_exec_unit.sv
// Bench for ls_exec_unit: scenario tasks drive ops and check the memory side;
// a scoreboard queue checks every CDB completion as it appears.
module tb_ls_exec_unit;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          issue_in = 1'b0;
  logic [5:0]    p_rd_in = '0;
  logic [3:0]    rob_num_in = '0;
  logic          mem_ren_in = 1'b0;
  logic          mem_wen_in = 1'b0;
  logic [15:0]   immed_in = '0;
  logic [DW-1:0] rs_data = '0;
  logic [DW-1:0] rt_data = '0;
  logic          recover = 1'b0;
  logic [3:0]    rob_num_rec = '0;
  logic          cdb_req;
  logic          cdb_grant = 1'b0;
  logic          complete_out;
  logic [5:0]    p_rd_compl_out;
  logic          RegDest_compl_out;
  logic [3:0]    rob_num_compl_out;
  logic [DW-1:0] result_out;
  logic          lsu_busy;

  ls_exec_unit_if #(.DW(DW)) mem ();

  ls_exec_unit #(.DW(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .issue_in          (issue_in),
    .p_rd_in           (p_rd_in),
    .rob_num_in        (rob_num_in),
    .mem_ren_in        (mem_ren_in),
    .mem_wen_in        (mem_wen_in),
    .immed_in          (immed_in),
    .rs_data           (rs_data),
    .rt_data           (rt_data),
    .recover           (recover),
    .rob_num_rec       (rob_num_rec),
    .mem               (mem),
    .cdb_req           (cdb_req),
    .cdb_grant         (cdb_grant),
    .complete_out      (complete_out),
    .p_rd_compl_out    (p_rd_compl_out),
    .RegDest_compl_out (RegDest_compl_out),
    .rob_num_compl_out (rob_num_compl_out),
    .result_out        (result_out),
    .lsu_busy          (lsu_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]    p_rd;
    logic          regdest;
    logic [3:0]    rob;
    logic [DW-1:0] result;
  } compl_t;

  compl_t sb[$];
  compl_t mon_exp;
  compl_t mon_got;
  int     n_checks = 0;
  int     n_pass   = 0;
  int     n_compl  = 0;

  initial begin
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;
  end

  // Scoreboard: every completion pulse must match the oldest expected op.
  always @(negedge clk) begin
    #2;
    if (rst === 1'b1 && complete_out === 1'b1) begin
      n_compl++;
      n_checks++;
      mon_got = {p_rd_compl_out, RegDest_compl_out, rob_num_compl_out, result_out};
      if (sb.size() == 0) begin
        $display("FAIL unexpected_complete: got %h required no completion", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp)
          $display("FAIL completion: got %h required %h", mon_got, mon_exp);
        else
          n_pass++;
      end
    end
  end

  // Drives one issue cycle, records the expected completion, and leaves
  // the bench at the negedge of the following cycle with issue_in low.
  task automatic issue_op(input logic [5:0] p_rd, input logic [3:0] rob,
                          input logic ren, input logic wen, input logic [15:0] imm,
                          input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                          input logic [DW-1:0] rdata, input bit expect_accept);
    compl_t e;
    @(negedge clk);
    cdb_grant   = 1'b0;
    mem.mem_ack = 1'b0;
    issue_in    = 1'b1;
    p_rd_in     = p_rd;
    rob_num_in  = rob;
    mem_ren_in  = ren;
    mem_wen_in  = wen;
    immed_in    = imm;
    rs_data     = rs;
    rt_data     = rt;
    if (expect_accept) begin
      e.p_rd    = p_rd;
      e.regdest = ren;
      e.rob     = rob;
      e.result  = ren ? rdata : '0;
      sb.push_back(e);
    end
    @(negedge clk);
    issue_in = 1'b0;
  endtask

  // Memory/CDB responder with bounded delays; reports what it observed.
  task automatic serve(input int ack_dly, input int grant_dly, input logic [DW-1:0] rdata,
                       output int req_cyc, output int cdb_cyc,
                       output logic [DW-1:0] addr0, output logic [DW-1:0] wdata0,
                       output logic we0, output bit stable, output bit busy_ok);
    req_cyc = 0;
    cdb_cyc = 0;
    stable  = 1'b1;
    busy_ok = 1'b1;
    addr0   = mem.mem_addr;
    wdata0  = mem.mem_wdata;
    we0     = mem.mem_we;
    for (int i = 0; i <= ack_dly; i++) begin
      if (i > 0) @(negedge clk);
      if (mem.mem_req === 1'b1) req_cyc++;
      if ({mem.mem_addr, mem.mem_wdata, mem.mem_we} !== {addr0, wdata0, we0}) stable = 1'b0;
      if (lsu_busy !== 1'b1) busy_ok = 1'b0;
      mem.mem_ack   = (i == ack_dly);
      mem.mem_rdata = (i == ack_dly) ? rdata : '0;
    end
    for (int i = 0; i <= grant_dly; i++) begin
      @(negedge clk);
      mem.mem_ack = 1'b0;
      if (cdb_req === 1'b1) cdb_cyc++;
      if (lsu_busy !== 1'b1) busy_ok = 1'b0;
      cdb_grant = (i == grant_dly);
    end
    @(negedge clk);
    cdb_grant = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata, cdb_req, complete_out} !== '0)
      $display("FAIL reset_mem_side: got %h required 0",
               {mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata, cdb_req, complete_out});
    else n_pass++;
    n_checks++;
    if ({p_rd_compl_out, RegDest_compl_out, rob_num_compl_out, result_out, lsu_busy} !== '0)
      $display("FAIL reset_cdb_side: got %h required 0",
               {p_rd_compl_out, RegDest_compl_out, rob_num_compl_out, result_out, lsu_busy});
    else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_load;
    int req_c, cdb_c, c0;
    logic [DW-1:0] a, w;
    logic we;
    bit st, bz;
    c0 = n_compl;
    issue_op(6'd5, 4'd3, 1'b1, 1'b0, 16'hFFFC, 16'h0100, 16'h0000, 16'hBEEF, 1'b1);
    serve(0, 0, 16'hBEEF, req_c, cdb_c, a, w, we, st, bz);
    n_checks++;
    if (a !== 16'h00FC || we !== 1'b0 || req_c != 1)
      $display("FAIL load_request: got addr %h we %b req %0d required 00fc 0 1", a, we, req_c);
    else n_pass++;
    n_checks++;
    if (cdb_c != 1 || n_compl - c0 != 1 || !bz)
      $display("FAIL load_latency: got cdb %0d compl %0d busy_ok %0d required 1 1 1",
               cdb_c, n_compl - c0, bz);
    else n_pass++;
    n_checks++;
    if (lsu_busy !== 1'b0 || cdb_req !== 1'b0)
      $display("FAIL load_release: got busy %b cdb_req %b required 0 0", lsu_busy, cdb_req);
    else n_pass++;
  endtask

  task automatic test_store;
    int req_c, cdb_c, c0;
    logic [DW-1:0] a, w;
    logic we;
    bit st, bz;
    c0 = n_compl;
    issue_op(6'd12, 4'd7, 1'b0, 1'b1, 16'h0004, 16'h0010, 16'h1234, 16'hDEAD, 1'b1);
    serve(1, 0, 16'hDEAD, req_c, cdb_c, a, w, we, st, bz);
    n_checks++;
    if (a !== 16'h0014 || w !== 16'h1234 || we !== 1'b1)
      $display("FAIL store_request: got %h %h %b required 0014 1234 1", a, w, we);
    else n_pass++;
    n_checks++;
    if (n_compl - c0 != 1)
      $display("FAIL store_complete: got %0d completions required 1", n_compl - c0);
    else n_pass++;
  endtask

  task automatic test_stalls;
    int req_c, cdb_c, c0;
    logic [DW-1:0] a, w;
    logic we;
    bit st, bz;
    c0 = n_compl;
    issue_op(6'd33, 4'd11, 1'b1, 1'b1, 16'h8000, 16'h7FF0, 16'h5555, 16'hA5A5, 1'b1);
    serve(3, 2, 16'hA5A5, req_c, cdb_c, a, w, we, st, bz);
    n_checks++;
    if (req_c != 4 || !st || a !== 16'hFFF0 || we !== 1'b0)
      $display("FAIL stall_mem: got req %0d stable %0d addr %h we %b required 4 1 fff0 0",
               req_c, st, a, we);
    else n_pass++;
    n_checks++;
    if (cdb_c != 3 || n_compl - c0 != 1)
      $display("FAIL stall_cdb: got cdb %0d compl %0d required 3 1", cdb_c, n_compl - c0);
    else n_pass++;
    n_checks++;
    if (!bz || lsu_busy !== 1'b0)
      $display("FAIL stall_busy: got busy_ok %0d busy_after %b required 1 0", bz, lsu_busy);
    else n_pass++;
  endtask

  task automatic test_recovery;
    int req_c, cdb_c, c0;
    logic [DW-1:0] a, w;
    logic we;
    bit st, bz;
    c0 = n_compl;
    // Matching tag in MEM, with a same-cycle ack that must be discarded.
    issue_op(6'd9, 4'd9, 1'b1, 1'b0, 16'h0002, 16'h0040, 16'h0000, 16'h1111, 1'b1);
    recover = 1'b1; rob_num_rec = 4'd9;
    mem.mem_ack = 1'b1; mem.mem_rdata = 16'h1111;
    @(negedge clk);
    recover = 1'b0; mem.mem_ack = 1'b0;
    void'(sb.pop_back());
    n_checks++;
    if ({mem.mem_req, cdb_req, lsu_busy} !== 3'b000)
      $display("FAIL flush_mem: got req/cdb/busy %b required 000", {mem.mem_req, cdb_req, lsu_busy});
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_compl != c0)
      $display("FAIL flush_no_complete: got %0d completions required 0", n_compl - c0);
    else n_pass++;
    // Matching tag in CDB with a same-cycle grant: the broadcast is lost.
    issue_op(6'd2, 4'd9, 1'b1, 1'b0, 16'h0000, 16'h0050, 16'h0000, 16'h2222, 1'b1);
    mem.mem_ack = 1'b1; mem.mem_rdata = 16'h2222;
    @(negedge clk);
    mem.mem_ack = 1'b0;
    recover = 1'b1; rob_num_rec = 4'd9; cdb_grant = 1'b1;
    #1;
    n_checks++;
    if (complete_out !== 1'b0)
      $display("FAIL flush_grant: got complete %b required 0", complete_out);
    else n_pass++;
    void'(sb.pop_back());
    @(negedge clk);
    recover = 1'b0; cdb_grant = 1'b0;
    n_checks++;
    if ({cdb_req, lsu_busy} !== 2'b00)
      $display("FAIL flush_cdb: got cdb/busy %b required 00", {cdb_req, lsu_busy});
    else n_pass++;
    // Non-matching tag has no effect.
    c0 = n_compl;
    issue_op(6'd40, 4'd9, 1'b1, 1'b0, 16'h0001, 16'h0060, 16'h0000, 16'h3333, 1'b1);
    recover = 1'b1; rob_num_rec = 4'd8;
    @(negedge clk);
    recover = 1'b0;
    serve(0, 0, 16'h3333, req_c, cdb_c, a, w, we, st, bz);
    n_checks++;
    if (req_c != 1 || a !== 16'h0061 || n_compl - c0 != 1)
      $display("FAIL nomatch_recover: got req %0d addr %h compl %0d required 1 0061 1",
               req_c, a, n_compl - c0);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int req_c, cdb_c, c0;
    logic [DW-1:0] a, w;
    logic we;
    bit st, bz;
    c0 = n_compl;
    issue_op(6'd1, 4'd1, 1'b1, 1'b0, 16'h0000, 16'h0100, 16'h0000, 16'hAAAA, 1'b1);
    // Second op presented while busy (MEM, then CDB): ignored.
    issue_in = 1'b1; p_rd_in = 6'd2; rob_num_in = 4'd2; mem_ren_in = 1'b1; mem_wen_in = 1'b0;
    rs_data = 16'h0200;
    mem.mem_ack = 1'b1; mem.mem_rdata = 16'hAAAA;
    @(negedge clk);
    mem.mem_ack = 1'b0;
    n_checks++;
    if (cdb_req !== 1'b1 || mem.mem_addr !== 16'h0100)
      $display("FAIL busy_ignore: got cdb_req %b addr %h required 1 0100", cdb_req, mem.mem_addr);
    else n_pass++;
    issue_in = 1'b0;
    cdb_grant = 1'b1;
    issue_op(6'd2, 4'd2, 1'b0, 1'b1, 16'hFFFF, 16'h0200, 16'h4321, 16'h0000, 1'b1);
    n_checks++;
    if (mem.mem_req !== 1'b1 || mem.mem_addr !== 16'h01FF || lsu_busy !== 1'b1)
      $display("FAIL reissue_accept: got req %b addr %h busy %b required 1 01ff 1",
               mem.mem_req, mem.mem_addr, lsu_busy);
    else n_pass++;
    serve(0, 1, 16'h0000, req_c, cdb_c, a, w, we, st, bz);
    n_checks++;
    if (n_compl - c0 != 2 || w !== 16'h4321)
      $display("FAIL back_to_back: got compl %0d wdata %h required 2 4321", n_compl - c0, w);
    else n_pass++;
    // Issue with neither read nor write, and issue during recover: both ignored.
    issue_op(6'd3, 4'd4, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    n_checks++;
    if (lsu_busy !== 1'b0)
      $display("FAIL noop_ignore: got busy %b required 0", lsu_busy);
    else n_pass++;
    recover = 1'b1; rob_num_rec = 4'd0;
    issue_op(6'd3, 4'd4, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    recover = 1'b0;
    n_checks++;
    if (lsu_busy !== 1'b0 || mem.mem_req !== 1'b0)
      $display("FAIL recover_issue_ignore: got busy %b req %b required 0 0", lsu_busy, mem.mem_req);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    issue_op(6'd7, 4'd6, 1'b1, 1'b0, 16'h0010, 16'h0300, 16'h0000, 16'h7777, 1'b1);
    mem.mem_ack = 1'b1; mem.mem_rdata = 16'h7777;
    @(negedge clk);
    mem.mem_ack = 1'b0;
    cdb_grant = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    void'(sb.pop_back());
    n_checks++;
    if ({mem.mem_req, mem.mem_addr, cdb_req, complete_out, lsu_busy} !== '0)
      $display("FAIL reset_mid_ctrl: got %h required 0",
               {mem.mem_req, mem.mem_addr, cdb_req, complete_out, lsu_busy});
    else n_pass++;
    n_checks++;
    if ({p_rd_compl_out, RegDest_compl_out, rob_num_compl_out, result_out} !== '0)
      $display("FAIL reset_mid_compl: got %h required 0",
               {p_rd_compl_out, RegDest_compl_out, rob_num_compl_out, result_out});
    else n_pass++;
    cdb_grant = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion of all scenarios");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_stalls();
    test_recovery();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
